led_event_blinker: RTL and testbench

Output-side counterpart to the button debouncer: converts single-cycle event flags from the SoC into human-visible LED blinks. Each accepted event produces exactly one blink, an ON phase followed by an OFF gap. Events arriving during a blink are queued in a saturating pending counter and replayed back-to-back. Sits between status/event logic and board LED pins in the FPGA top.

---
 rtl/led_blink_pkg.sv | 22 ++
 rtl/led_pwm_gen.sv | 30 +++
 rtl/led_event_blinker.sv | 128 ++++++++++++
 tb/tb_led_event_blinker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// ---------------------------------------------------------------------------
// led_blink_pkg
// Shared definitions for the LED event blinker:
//   - blink_state_t : FSM state encoding (IDLE, ON, GAP)
//   - DEF_*         : default timing/width constants for a 50 MHz clock
// ---------------------------------------------------------------------------
package led_blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } blink_state_t;

  // 100 ms on / 100 ms off at 50 MHz
  localparam int unsigned DEF_ON_CYCLES  = 5_000_000;
  localparam int unsigned DEF_OFF_CYCLES = 5_000_000;
  localparam int unsigned DEF_CNT_W      = 23;
  localparam int unsigned DEF_PEND_W     = 4;
  localparam logic [7:0]  DEF_DIM_DUTY   = 8'd16;

endpackage

// File: rtl/led_pwm_gen.sv
// ---------------------------------------------------------------------------
// led_pwm_gen
// Idle-glow generator: free-running 8-bit counter with a duty compare.
// dim_o is high for DIM_DUTY out of every 256 cycles.
// Ports:
//   clk   : system clock
//   rstn  : synchronous active-low reset (counter restarts at 0)
//   dim_o : glow enable, high while counter < DIM_DUTY
// ---------------------------------------------------------------------------
module led_pwm_gen #(
  parameter logic [7:0] DIM_DUTY = 8'd16
) (
  input  logic clk,
  input  logic rstn,
  output logic dim_o
);

  logic [7:0] r_pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;  // wraps 255 -> 0
    end
  end

  assign dim_o = (r_pwm_cnt < DIM_DUTY);

endmodule

// File: rtl/led_event_blinker.sv
// ---------------------------------------------------------------------------
// led_event_blinker
// Turns single-cycle event flags into visible LED blinks. Each accepted event
// gives one ON phase (ON_CYCLES) followed by one OFF gap (OFF_CYCLES). Events
// arriving while busy are queued in a saturating pending counter and replayed
// back-to-back with no idle cycle in between.
//
// Optional build macro: LED_DIM_EN
//   defined   -> LED glows at DIM_DUTY/256 while idle (via led_pwm_gen)
//   undefined -> LED fully off while idle
//
// Ports:
//   clk        : system clock
//   rstn       : synchronous active-low reset
//   event_i    : event flag, each high cycle is one event
//   clear_i    : clears pending count and overflow flag
//   led_o      : LED drive, active-high
//   busy_o     : blinking or events pending
//   pending_o  : queued events not yet started
//   overflow_o : sticky, an event was dropped at saturation
// ---------------------------------------------------------------------------
module led_event_blinker
  import led_blink_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
  parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned PEND_W     = DEF_PEND_W,
  parameter logic [7:0]  DIM_DUTY   = DEF_DIM_DUTY
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              event_i,
  input  logic              clear_i,
  output logic              led_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  blink_state_t      r_state;
  logic [CNT_W-1:0]  r_timer;
  logic [PEND_W-1:0] r_pending;
  logic              r_overflow;

  logic w_pend_nz;
  logic w_start;
  logic w_dim;

  assign w_pend_nz = (r_pending != '0);

  // A new blink starts from IDLE or straight out of the last GAP cycle.
  // A clear in the same cycle empties the queue, so nothing is started.
  assign w_start = w_pend_nz && !clear_i &&
                   ((r_state == IDLE) || ((r_state == GAP) && (r_timer == OFF_LAST)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      // phase sequencing
      unique case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_start) r_state <= ON;
        end
        ON: begin
          if (r_timer == ON_LAST) begin
            r_state <= GAP;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        GAP: begin
          if (r_timer == OFF_LAST) begin
            r_state <= w_start ? ON : IDLE;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_timer <= '0;
        end
      endcase

      // pending queue: clear dominates; simultaneous inc/dec cancel
      if (clear_i) begin
        r_pending  <= '0;
        r_overflow <= 1'b0;
      end else if (event_i && !w_start) begin
        if (r_pending == PEND_MAX) r_overflow <= 1'b1;
        else                       r_pending  <= r_pending + PEND_W'(1);
      end else if (!event_i && w_start) begin
        r_pending <= r_pending - PEND_W'(1);
      end
    end
  end

`ifdef LED_DIM_EN
  led_pwm_gen #(
    .DIM_DUTY (DIM_DUTY)
  ) u_pwm (
    .clk   (clk),
    .rstn  (rstn),
    .dim_o (w_dim)
  );
`else
  // No glow: the duty parameter is kept so both builds share one interface.
  assign w_dim = (DIM_DUTY == 8'hFF) && 1'b0;
`endif

  // Outputs decode registered state only; nothing combinational from inputs.
  assign led_o      = (r_state == ON) || ((r_state == IDLE) && w_dim);
  assign busy_o     = (r_state != IDLE) || w_pend_nz;
  assign pending_o  = r_pending;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_led_event_blinker.sv
module tb_led_event_blinker;

  localparam int ON_C   = 4;
  localparam int OFF_C  = 3;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;
  localparam int DUTY   = 64;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              event_i = 1'b0;
  logic              clear_i = 1'b0;
  logic              led_o;
  logic              busy_o;
  logic [PEND_W-1:0] pending_o;
  logic              overflow_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: queue length, sticky flag, cycles left in current blink
  int m_pend = 0;
  int m_ovf  = 0;
  int m_left = 0;
  int m_pwm  = 0;

  always #5 clk = ~clk;

  led_event_blinker #(
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .CNT_W      (3),
    .PEND_W     (PEND_W),
    .DIM_DUTY   (8'd64)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .event_i    (event_i),
    .clear_i    (clear_i),
    .led_o      (led_o),
    .busy_o     (busy_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  function automatic logic [PEND_W+2:0] exp_vec();
    logic l;
    l = (m_left > OFF_C);
`ifdef LED_DIM_EN
    if (m_left == 0 && m_pwm < DUTY) l = 1'b1;
`endif
    return {l, (m_left > 0 || m_pend > 0), PEND_W'(m_pend), (m_ovf != 0)};
  endfunction

  // Apply one cycle of inputs and advance the model to the post-edge state.
  task automatic tick(input bit ev, input bit clr, input bit rst);
    bit start;
    int p;
    event_i = ev;
    clear_i = clr;
    rstn    = !rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_pend = 0; m_ovf = 0; m_left = 0; m_pwm = 0;
    end else begin
      start = (m_left <= 1) && (m_pend > 0) && !clr;
      if (clr) begin
        p = 0; m_ovf = 0;
      end else begin
        p = m_pend + int'(ev) - int'(start);
        if (p > PMAX) begin p = PMAX; m_ovf = 1; end
      end
      m_pend = p;
      m_left = start ? (ON_C + OFF_C) : ((m_left > 0) ? m_left - 1 : 0);
      m_pwm  = (m_pwm + 1) % 256;
    end
    #1;
    event_i = 1'b0;
    clear_i = 1'b0;
    rstn    = 1'b1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 1'b0, 1'b1);
      n_vec++;
      if ({led_o, busy_o, pending_o, overflow_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", cyc,
                 {led_o, busy_o, pending_o, overflow_o}, exp_vec());
      end
    end
    n_vec++;
    if (pending_o !== '0 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_zero got pend=%0d busy=%b ovf=%b exp 0/0/0", pending_o, busy_o, overflow_o);
    end
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    tick(1'b0, 1'b0, 1'b1);
    for (int c = 1; c < 30; c++) begin
      tick(c == 10, 1'b0, 1'b0);
      busy_cnt += int'(busy_o);
      n_vec++;
      if ({led_o, busy_o, pending_o, overflow_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL single cyc=%0d got=%b exp=%b", cyc,
                 {led_o, busy_o, pending_o, overflow_o}, exp_vec());
      end
    end
    n_vec++;
    if (busy_cnt !== 1 + ON_C + OFF_C) begin
      n_err++;
      $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, 1 + ON_C + OFF_C);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt = 0;
    int peak = 0;
    tick(1'b0, 1'b0, 1'b1);
    for (int c = 1; c < 40; c++) begin
      tick(c >= 10 && c <= 12, 1'b0, 1'b0);
      busy_cnt += int'(busy_o);
      if (int'(pending_o) > peak) peak = int'(pending_o);
      n_vec++;
      if ({led_o, busy_o, pending_o, overflow_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc,
                 {led_o, busy_o, pending_o, overflow_o}, exp_vec());
      end
    end
    n_vec++;
    if (busy_cnt !== 1 + 3 * (ON_C + OFF_C) || peak !== 2) begin
      n_err++;
      $display("FAIL b2b_shape got busy=%0d peak=%0d exp busy=%0d peak=2",
               busy_cnt, peak, 1 + 3 * (ON_C + OFF_C));
    end
  endtask

  task automatic test_overflow();
    int busy_cnt = 0;
    int peak = 0;
    tick(1'b0, 1'b0, 1'b1);
    for (int c = 1; c < 50; c++) begin
      tick(c == 10 || (c >= 13 && c <= 17), 1'b0, 1'b0);
      busy_cnt += int'(busy_o);
      if (int'(pending_o) > peak) peak = int'(pending_o);
      n_vec++;
      if ({led_o, busy_o, pending_o, overflow_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc,
                 {led_o, busy_o, pending_o, overflow_o}, exp_vec());
      end
    end
    n_vec++;
    if (overflow_o !== 1'b1 || peak !== PMAX || busy_cnt !== 1 + 4 * (ON_C + OFF_C)) begin
      n_err++;
      $display("FAIL overflow_end got ovf=%b peak=%0d busy=%0d exp ovf=1 peak=%0d busy=%0d",
               overflow_o, peak, busy_cnt, PMAX, 1 + 4 * (ON_C + OFF_C));
    end
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    tick(1'b0, 1'b0, 1'b1);
    for (int c = 1; c < 30; c++) begin
      tick(c >= 10 && c <= 12, c == 14, 1'b0);
      busy_cnt += int'(busy_o);
      n_vec++;
      if ({led_o, busy_o, pending_o, overflow_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL clear cyc=%0d got=%b exp=%b", cyc,
                 {led_o, busy_o, pending_o, overflow_o}, exp_vec());
      end
    end
    // only the first blink survives the clear
    n_vec++;
    if (busy_cnt !== 1 + ON_C + OFF_C || overflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL clear_end got busy=%0d ovf=%b exp busy=%0d ovf=0",
               busy_cnt, overflow_o, 1 + ON_C + OFF_C);
    end
  endtask

  task automatic test_clear_event_and_reset();
    tick(1'b0, 1'b0, 1'b1);
    for (int c = 1; c < 30; c++) begin
      // c==5: clear with event in idle; c==10: event; c==13: reset mid-ON
      tick(c == 5 || c == 10, c == 5, c == 13);
      n_vec++;
      if ({led_o, busy_o, pending_o, overflow_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL clr_rst cyc=%0d got=%b exp=%b", cyc,
                 {led_o, busy_o, pending_o, overflow_o}, exp_vec());
      end
      if (c == 6 || c == 13) begin
        n_vec++;
        if (busy_o !== 1'b0 || pending_o !== '0) begin
          n_err++;
          $display("FAIL clr_rst_idle cyc=%0d got busy=%b pend=%0d exp 0/0", cyc, busy_o, pending_o);
        end
      end
    end
  endtask

  task automatic test_random();
    int dens;
    tick(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 900; c++) begin
      dens = (c < 300) ? 5 : ((c < 600) ? 30 : 70);
      tick($urandom_range(0, 99) < dens, $urandom_range(0, 99) < 2,
           $urandom_range(0, 999) < 4);
      n_vec++;
      if ({led_o, busy_o, pending_o, overflow_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc,
                 {led_o, busy_o, pending_o, overflow_o}, exp_vec());
      end
    end
  endtask

`ifdef LED_DIM_EN
  task automatic test_dim();
    int on_cnt = 0;
    tick(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 512; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      on_cnt += int'(led_o);
      n_vec++;
      if ({led_o, busy_o, pending_o, overflow_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL dim cyc=%0d got=%b exp=%b", cyc,
                 {led_o, busy_o, pending_o, overflow_o}, exp_vec());
      end
    end
    n_vec++;
    if (on_cnt !== 2 * DUTY) begin
      n_err++;
      $display("FAIL dim_duty got=%0d exp=%0d", on_cnt, 2 * DUTY);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_clear_event_and_reset();
    test_random();
`ifdef LED_DIM_EN
    test_dim();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
